// File: rtl/skinny_round_ctrl.sv
// rtl/skinny_round_ctrl.sv - round/stage sequencer for the masked SKINNY-64-64 core
module skinny_round_ctrl #(
    parameter int ROUNDS      = 32,
    parameter int SBOX_STAGES = 3,
    parameter int CNT_W       = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   sel,
    output logic                   en_state,
    output logic                   en_key,
    output logic [SBOX_STAGES-1:0] en_stage,
    output logic [5:0]             rc,
    output logic [CNT_W-1:0]       round_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int SW = (SBOX_STAGES > 1) ? $clog2(SBOX_STAGES) : 1;
    localparam logic [SW-1:0]    LAST_STG = SW'(SBOX_STAGES - 1);
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DONE
    } state_t;

    state_t                   state, state_d;
    logic [SW-1:0]            stg, stg_d;
    logic [CNT_W-1:0]         ridx_d;
    logic [5:0]               rc_d;
    logic                     sel_d, en_state_d, en_key_d, busy_d, done_d;
    logic [SBOX_STAGES-1:0]   en_stage_d;

    always_comb begin
        state_d = state;
        stg_d   = stg;
        ridx_d  = round_idx;
        rc_d    = rc;
        case (state)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                state_d = ROUND;
                stg_d   = '0;
                ridx_d  = CNT_W'(1);
                rc_d    = 6'h01;
            end
            ROUND: begin
                if (stg == LAST_STG) begin
                    stg_d = '0;
                    if (round_idx == LAST_RND) begin
                        state_d = DONE;
                        ridx_d  = '0;
                        rc_d    = '0;
                    end else begin
                        ridx_d = round_idx + CNT_W'(1);
                        rc_d   = {rc[4:0], ~(rc[5] ^ rc[4])};
                    end
                end else begin
                    stg_d = stg + SW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // and still line up with the cycle the FSM is actually in.
    always_comb begin
        sel_d      = 1'b0;
        en_state_d = 1'b0;
        en_key_d   = 1'b0;
        en_stage_d = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            LOAD: begin
                en_state_d = 1'b1;
                en_key_d   = 1'b1;
                busy_d     = 1'b1;
            end
            ROUND: begin
                sel_d      = 1'b1;
                busy_d     = 1'b1;
                en_stage_d = SBOX_STAGES'(1) << stg_d;
                en_state_d = (stg_d == LAST_STG);
                en_key_d   = (stg_d == LAST_STG);
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stg       <= '0;
            round_idx <= '0;
            rc        <= 6'h00;
            sel       <= 1'b0;
            en_state  <= 1'b0;
            en_key    <= 1'b0;
            en_stage  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            stg       <= stg_d;
            round_idx <= ridx_d;
            rc        <= rc_d;
            sel       <= sel_d;
            en_state  <= en_state_d;
            en_key    <= en_key_d;
            en_stage  <= en_stage_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: doc/skinny_round_ctrl.md
Name: skinny_round_ctrl

Overview:
Control sequencer for the second-order masked SKINNY-64-64 encryption core with a 3-stage S-box pipeline. It drives the select and enable inputs of the muxed, enabled state and key flip-flop banks. It also drives the per-stage enables of the masked S-box pipeline registers and supplies the 6-bit round constant. It sits directly upstream of the state/key register banks and runs one encryption per start pulse.

Parameters:
ROUNDS, 32, number of SKINNY rounds per encryption (2..63)
SBOX_STAGES, 3, register stages in the masked S-box; cycles per round (1..4)
CNT_W, 6, width of round counter; must hold ROUNDS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin encryption; sampled only in IDLE
sel  output  1  state/key mux select: 0 = load external input (D0), 1 = round feedback (D1)
en_state  output  1  enable for state flip-flop bank
en_key  output  1  enable for key flip-flop bank
en_stage  output  SBOX_STAGES  one-hot enable for S-box pipeline register stage k
rc  output  6  round constant for the current round
round_idx  output  CNT_W  current round number, 1..ROUNDS; 0 outside ROUND
busy  output  1  high in LOAD and ROUND
done  output  1  one-cycle pulse when ciphertext is valid in the state bank

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; stage counter=0; round_idx=0; rc=6'h00; sel=0; en_state=0; en_key=0; en_stage=0; busy=0; done=0. Release is synchronous to clk. rst_n low at any point, mid-encryption included, aborts immediately to these values. No partial result is flagged.
- All outputs are registered. No combinational path from start to any output.
- States: IDLE, LOAD, ROUND, DONE.
- IDLE: outputs at reset values. If start=1, next state is LOAD.
- LOAD (1 cycle):
  - sel=0, en_state=1, en_key=1, busy=1; plaintext and key shares are captured at the end of this cycle.
  - rc is loaded with 6'h01; round_idx with 1; stage counter with 0.
  - Next state: ROUND.
- ROUND (ROUNDS*SBOX_STAGES cycles):
  - sel=1 and busy=1 throughout; en_stage is one-hot at bit [stage counter].
  - en_state and en_key are 1 only when stage counter = SBOX_STAGES-1, otherwise 0.
  - On that last stage cycle: stage counter wraps to 0 and rc advances.
    - rc LFSR update: new = {rc[4:0], rc[5]^rc[4]^1}.
    - If round_idx = ROUNDS, next state is DONE; otherwise round_idx increments.
  - On any other cycle, stage counter increments.
- DONE (1 cycle): done=1, busy=0, all enables 0, sel=0. rc and round_idx clear to 0. Next state is IDLE.
- start is ignored in LOAD, ROUND and DONE; no queuing. A start in the cycle after DONE (IDLE) is accepted.
- Latency: start high at edge N (IDLE) gives LOAD in cycle N+1. Final state write happens at the end of cycle N+1+ROUNDS*SBOX_STAGES. done is high in cycle N+2+ROUNDS*SBOX_STAGES (defaults: N+98).
- Fresh-mask refresh is not controlled here; randomness is consumed every cycle by the S-box.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with start=1 -> all outputs 0, no LOAD; release with start=0 -> stays IDLE.
2. Single run at defaults:
   - start pulse at cycle 0 -> LOAD at cycle 1 (sel=0, en_state=1).
   - en_state high at cycles 4,7,...,97 (32 pulses); en_stage cycles 001,010,100.
   - done high only at cycle 98; busy high for cycles 1..97.
3. Round constants: rc sampled on each en_state pulse in ROUND -> 01,03,07,0F,1F,3E,3D,3B,... and round 32 = 0x38; round_idx 1..32.
4. start held high continuously -> exactly one LOAD per run. Next LOAD occurs at cycle 100, one IDLE cycle after done.
5. rst_n asserted at cycle 40 mid-ROUND -> outputs go to reset values asynchronously, before the next clock edge. No done pulse appears; a new start after release runs a full 98-cycle sequence.
6. Parameter variant ROUNDS=4, SBOX_STAGES=1 -> en_state high at cycles 1..5 (LOAD + 4 rounds); done at cycle 6; rc sequence 01,03,07,0F.
